decode_stage: RTL and testbench
===============================

DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning datapath/PC/immediate width (legal values 32 or 64).
REQ-002 SHALL have parameter QDEPTH, default 2, meaning instruction queue depth (power of 2, 2..16).
REQ-003 SHALL have one clock; reset is asynchronous and active-high; port clk, input, 1, rising-edge clock.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have ports in_valid (in, 1), in_ready (out, 1), in_instr (in, 32) and in_pc (in, XLEN), the fetch-side handshake and payload.
REQ-006 SHALL have port flush, input, 1, meaning discard all queued and registered instructions.
REQ-007 SHALL have ports ex_valid (in, 1), ex_is_load (in, 1) and ex_rd (in, 5), the execute-stage destination used for load-use detection.
REQ-008 SHALL have ports out_valid (out, 1) and out_ready (in, 1), the execute-side handshake.
REQ-009 SHALL have registered outputs:
- alu_op (5)
- reg_write_en (1)
- br_type (2)
- ram_write_en (1)
- ram_read_en (1)
- ram_type (4)
- ram_sign (1)
- mux_op1_select (1)
- mux_op2_select (1)
- mux_br_sel (1)
- mux_writeback (2)
- rs1, rs2, rd (5 each)
- imm (XLEN)
- out_pc (XLEN)
- illegal (1)

Function
REQ-010 SHALL buffer accepted {instr, pc} in a QDEPTH-entry FIFO; push when in_valid && in_ready; in_ready = !full, with no same-cycle bypass when full.
REQ-011 SHALL decode the FIFO head combinationally and load the output register when (!out_valid || out_ready) && !empty && !hazard, popping the head in the same cycle.
REQ-012 SHALL have minimum latency of 1 cycle: an instruction accepted on edge N SHALL present out_valid=1 after edge N+1.
REQ-013 SHALL keep all outputs stable while out_valid && !out_ready.
REQ-014 SHALL clear out_valid on an edge where out_ready=1 and nothing is loaded.
REQ-015 SHALL assert hazard when ex_valid && ex_is_load && ex_rd!=0 && (ex_rd==head.rs1 for opcodes using rs1, or ex_rd==head.rs2 for OP/STORE/BRANCH); this inserts a bubble and keeps the head.
REQ-016 SHALL decode the control fields as the current single-cycle control decoder does: opcodes OP, OP_IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC; ALU codes and writeback codes from the global definitions.
REQ-017 SHALL set ram_sign=0 only for LBU/LHU and ram_sign=1 otherwise.
REQ-018 SHALL generate imm in I/S/B/U/J format, sign-extended to XLEN; the R-type imm SHALL be 0.
REQ-019 SHALL set illegal=1 for an unrecognised opcode or an undefined funct3/funct7 combination, with reg_write_en, ram_write_en, ram_read_en=0 and br_type=NONE; illegal instructions still flow through the handshake.
REQ-020 SHALL treat the FIFO as wrap-around: the read and write pointers are log2(QDEPTH) bits plus one wrap bit; full/empty are derived from the pointers.
REQ-021 SHALL, on flush, empty the FIFO and clear out_valid at the same edge; an in_valid presented in a flush cycle SHALL be dropped and in_ready SHALL read 0 during flush; flush overrides push, pop and load.
REQ-022 SHALL give hazard priority over load but not over flush.

Reset
REQ-023 SHALL, on rst, asynchronously set the FIFO pointers to 0, out_valid=0, illegal=0, and all control outputs to 0; br_type SHALL be NONE, mux_writeback WB_NO_DATA, imm/out_pc/rs1/rs2/rd 0.
REQ-024 SHALL, when rst asserts mid-transfer, lose all in-flight instructions; in_ready SHALL be 1 on the first edge after rst deasserts.

Configuration
REQ-025 SHALL, when DECODE_M_EN is defined, decode OP with funct7=0000001 as MUL..REMU with alu_op = 5'd24 + funct3, reg_write_en=1, mux_writeback=WB_ALU_OUT; when it is undefined, these encodings SHALL set illegal=1.

Verification
REQ-026 SHALL cover: ADDI x1,x0,5 (0x00500093) with out_ready=1 -> alu_op=ADD, imm=5, rd=1, reg_write_en=1, out_valid one cycle after acceptance.
REQ-027 SHALL cover: ex_valid=1, ex_is_load=1, ex_rd=3 with head ADD x4,x3,x2 -> out_valid=0 bubble; the instruction issues the cycle after ex_valid drops.
REQ-028 SHALL cover: QDEPTH pushes with out_ready=0 -> in_ready=0 after the queue fills, next push ignored; out_ready=1 drains all entries in order with correct out_pc.
REQ-029 SHALL cover: flush with 2 queued instructions and in_valid=1 -> out_valid=0 next cycle, FIFO empty, flush-cycle instruction never emerges.
REQ-030 SHALL cover: LHU (funct3=101) -> ram_type=HALFWORD, ram_sign=0; LH -> ram_sign=1; opcode 0x7F -> illegal=1, all enables 0.
REQ-031 SHALL cover: MUL x5,x6,x7 (0x027302B3) -> with DECODE_M_EN alu_op=5'd24, illegal=0; without it illegal=1.

Source files
------------

// File: rtl/decode_stage.sv
// Decode stage: a small instruction FIFO feeding a RISC-V control decoder with a
// registered, valid/ready output. Define DECODE_M_EN to decode the M extension.
module decode_stage #(
   parameter int XLEN   = 32,
   parameter int QDEPTH = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_instr,
   input  logic [XLEN-1:0] in_pc,
   input  logic            flush,
   input  logic            ex_valid,
   input  logic            ex_is_load,
   input  logic [4:0]      ex_rd,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [4:0]      alu_op,
   output logic            reg_write_en,
   output logic [1:0]      br_type,
   output logic            ram_write_en,
   output logic            ram_read_en,
   output logic [3:0]      ram_type,
   output logic            ram_sign,
   output logic            mux_op1_select,
   output logic            mux_op2_select,
   output logic            mux_br_sel,
   output logic [1:0]      mux_writeback,
   output logic [4:0]      rs1,
   output logic [4:0]      rs2,
   output logic [4:0]      rd,
   output logic [XLEN-1:0] imm,
   output logic [XLEN-1:0] out_pc,
   output logic            illegal
);

   localparam int AW = $clog2(QDEPTH);
   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

   localparam logic [4:0] ALU_ADD    = 5'd0;
   localparam logic [4:0] ALU_SUB    = 5'd1;
   localparam logic [4:0] ALU_SLL    = 5'd2;
   localparam logic [4:0] ALU_SLT    = 5'd3;
   localparam logic [4:0] ALU_SLTU   = 5'd4;
   localparam logic [4:0] ALU_XOR    = 5'd5;
   localparam logic [4:0] ALU_SRL    = 5'd6;
   localparam logic [4:0] ALU_SRA    = 5'd7;
   localparam logic [4:0] ALU_OR     = 5'd8;
   localparam logic [4:0] ALU_AND    = 5'd9;
   localparam logic [4:0] ALU_COPY_B = 5'd10;
   localparam logic [4:0] ALU_EQ     = 5'd11;
   localparam logic [4:0] ALU_NE     = 5'd12;
   localparam logic [4:0] ALU_LT     = 5'd13;
   localparam logic [4:0] ALU_GE     = 5'd14;
   localparam logic [4:0] ALU_LTU    = 5'd15;
   localparam logic [4:0] ALU_GEU    = 5'd16;
`ifdef DECODE_M_EN
   localparam logic [4:0] ALU_MUL    = 5'd24;
`endif

   localparam logic [1:0] BR_NONE = 2'd0;
   localparam logic [1:0] BR_COND = 2'd1;
   localparam logic [1:0] BR_JAL  = 2'd2;
   localparam logic [1:0] BR_JALR = 2'd3;

   localparam logic [3:0] RAM_NONE     = 4'd0;
   localparam logic [3:0] RAM_BYTE     = 4'd1;
   localparam logic [3:0] RAM_HALFWORD = 4'd2;
   localparam logic [3:0] RAM_WORD     = 4'd4;
   localparam logic [3:0] RAM_DOUBLE   = 4'd8;

   localparam logic [1:0] WB_NO_DATA  = 2'd0;
   localparam logic [1:0] WB_ALU_OUT  = 2'd1;
   localparam logic [1:0] WB_RAM_DATA = 2'd2;
   localparam logic [1:0] WB_PC_PLUS4 = 2'd3;

   logic [31:0]     q_instr [QDEPTH];
   logic [XLEN-1:0] q_pc    [QDEPTH];
   logic [AW:0]     wr_ptr, rd_ptr;
   logic            full, empty, push, load_out, hazard;
   logic [31:0]     head;
   logic [XLEN-1:0] head_pc;

   assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign empty    = (wr_ptr == rd_ptr);
   assign in_ready = !full && !flush;
   assign push     = in_valid && in_ready;
   assign head     = q_instr[rd_ptr[AW-1:0]];
   assign head_pc  = q_pc[rd_ptr[AW-1:0]];
   assign load_out = (!out_valid || out_ready) && !empty && !hazard && !flush;

   always_ff @(posedge clk) begin
      if (push) begin
         q_instr[wr_ptr[AW-1:0]] <= in_instr;
         q_pc[wr_ptr[AW-1:0]]    <= in_pc;
      end
   end

   // Flush drops everything, so both pointers return to a common empty position.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push)     wr_ptr <= wr_ptr + PTR_ONE;
         if (load_out) rd_ptr <= rd_ptr + PTR_ONE;
      end
   end

   logic [6:0] opcode, funct7;
   logic [2:0] funct3;
   logic       uses_rs1, uses_rs2, shift_ok_l, shift_ok_r;

   assign opcode = head[6:0];
   assign funct3 = head[14:12];
   assign funct7 = head[31:25];
   assign uses_rs1 = (opcode == OPC_OP) || (opcode == OPC_OP_IMM) || (opcode == OPC_LOAD) ||
                     (opcode == OPC_STORE) || (opcode == OPC_BRANCH) || (opcode == OPC_JALR);
   assign uses_rs2 = (opcode == OPC_OP) || (opcode == OPC_STORE) || (opcode == OPC_BRANCH);
   assign hazard = ex_valid && ex_is_load && (ex_rd != 5'd0) &&
                   ((uses_rs1 && ex_rd == head[19:15]) || (uses_rs2 && ex_rd == head[24:20]));
   // RV64 shift amounts are six bits wide, so bit 25 only has to be zero on RV32.
   assign shift_ok_l = (head[31:26] == 6'b000000) && ((XLEN == 64) || !head[25]);
   assign shift_ok_r = ((head[31:26] == 6'b000000) || (head[31:26] == 6'b010000)) &&
                       ((XLEN == 64) || !head[25]);

   logic [4:0]      d_alu_op, base_alu;
   logic [1:0]      d_br_type, d_wb;
   logic [3:0]      d_ram_type;
   logic [XLEN-1:0] d_imm;
   logic            d_reg_write_en, d_ram_write_en, d_ram_read_en, d_ram_sign;
   logic            d_op1, d_op2, d_br_sel, legal;

   always_comb begin
      base_alu       = ALU_ADD;
      d_alu_op       = ALU_ADD;
      d_reg_write_en = 1'b0;
      d_br_type      = BR_NONE;
      d_ram_write_en = 1'b0;
      d_ram_read_en  = 1'b0;
      d_ram_type     = RAM_NONE;
      d_ram_sign     = 1'b1;
      d_op1          = 1'b0;
      d_op2          = 1'b0;
      d_br_sel       = 1'b0;
      d_wb           = WB_NO_DATA;
      d_imm          = '0;
      legal          = 1'b1;
      case (funct3)
         3'b000:  base_alu = ALU_ADD;
         3'b001:  base_alu = ALU_SLL;
         3'b010:  base_alu = ALU_SLT;
         3'b011:  base_alu = ALU_SLTU;
         3'b100:  base_alu = ALU_XOR;
         3'b101:  base_alu = ALU_SRL;
         3'b110:  base_alu = ALU_OR;
         default: base_alu = ALU_AND;
      endcase
      case (opcode)
         OPC_OP: begin
            d_reg_write_en = 1'b1;
            d_wb           = WB_ALU_OUT;
            case (funct7)
               7'b0000000: d_alu_op = base_alu;
               7'b0100000: begin
                  if (funct3 == 3'b000)      d_alu_op = ALU_SUB;
                  else if (funct3 == 3'b101) d_alu_op = ALU_SRA;
                  else                       legal    = 1'b0;
               end
`ifdef DECODE_M_EN
               7'b0000001: d_alu_op = ALU_MUL + {2'b00, funct3};
`endif
               default: legal = 1'b0;
            endcase
         end
         OPC_OP_IMM: begin
            d_reg_write_en = 1'b1;
            d_wb           = WB_ALU_OUT;
            d_op2          = 1'b1;
            d_imm          = XLEN'($signed(head[31:20]));
            d_alu_op       = (funct3 == 3'b101 && head[30]) ? ALU_SRA : base_alu;
            if (funct3 == 3'b001)      legal = shift_ok_l;
            else if (funct3 == 3'b101) legal = shift_ok_r;
         end
         OPC_LOAD: begin
            d_reg_write_en = 1'b1;
            d_ram_read_en  = 1'b1;
            d_wb           = WB_RAM_DATA;
            d_op2          = 1'b1;
            d_imm          = XLEN'($signed(head[31:20]));
            case (funct3)
               3'b000: d_ram_type = RAM_BYTE;
               3'b001: d_ram_type = RAM_HALFWORD;
               3'b010: d_ram_type = RAM_WORD;
               3'b011: begin
                  if (XLEN == 64) d_ram_type = RAM_DOUBLE;
                  else            legal      = 1'b0;
               end
               3'b100: begin
                  d_ram_type = RAM_BYTE;
                  d_ram_sign = 1'b0;
               end
               3'b101: begin
                  d_ram_type = RAM_HALFWORD;
                  d_ram_sign = 1'b0;
               end
               default: legal = 1'b0;
            endcase
         end
         OPC_STORE: begin
            d_ram_write_en = 1'b1;
            d_op2          = 1'b1;
            d_imm          = XLEN'($signed({head[31:25], head[11:7]}));
            case (funct3)
               3'b000: d_ram_type = RAM_BYTE;
               3'b001: d_ram_type = RAM_HALFWORD;
               3'b010: d_ram_type = RAM_WORD;
               3'b011: begin
                  if (XLEN == 64) d_ram_type = RAM_DOUBLE;
                  else            legal      = 1'b0;
               end
               default: legal = 1'b0;
            endcase
         end
         OPC_BRANCH: begin
            d_br_type = BR_COND;
            d_imm     = XLEN'($signed({head[31], head[7], head[30:25], head[11:8], 1'b0}));
            case (funct3)
               3'b000:  d_alu_op = ALU_EQ;
               3'b001:  d_alu_op = ALU_NE;
               3'b100:  d_alu_op = ALU_LT;
               3'b101:  d_alu_op = ALU_GE;
               3'b110:  d_alu_op = ALU_LTU;
               3'b111:  d_alu_op = ALU_GEU;
               default: legal    = 1'b0;
            endcase
         end
         OPC_JAL: begin
            d_reg_write_en = 1'b1;
            d_wb           = WB_PC_PLUS4;
            d_br_type      = BR_JAL;
            d_op1          = 1'b1;
            d_op2          = 1'b1;
            d_imm          = XLEN'($signed({head[31], head[19:12], head[20], head[30:21], 1'b0}));
         end
         OPC_JALR: begin
            d_reg_write_en = 1'b1;
            d_wb           = WB_PC_PLUS4;
            d_br_type      = BR_JALR;
            d_op2          = 1'b1;
            d_br_sel       = 1'b1;
            d_imm          = XLEN'($signed(head[31:20]));
            legal          = (funct3 == 3'b000);
         end
         OPC_LUI: begin
            d_reg_write_en = 1'b1;
            d_wb           = WB_ALU_OUT;
            d_alu_op       = ALU_COPY_B;
            d_op2          = 1'b1;
            d_imm          = XLEN'($signed({head[31:12], 12'b0}));
         end
         OPC_AUIPC: begin
            d_reg_write_en = 1'b1;
            d_wb           = WB_ALU_OUT;
            d_op1          = 1'b1;
            d_op2          = 1'b1;
            d_imm          = XLEN'($signed({head[31:12], 12'b0}));
         end
         default: legal = 1'b0;
      endcase
      // Illegal encodings still travel downstream, but must not cause any side effect.
      if (!legal) begin
         d_alu_op       = ALU_ADD;
         d_reg_write_en = 1'b0;
         d_br_type      = BR_NONE;
         d_ram_write_en = 1'b0;
         d_ram_read_en  = 1'b0;
         d_ram_type     = RAM_NONE;
         d_ram_sign     = 1'b1;
         d_op1          = 1'b0;
         d_op2          = 1'b0;
         d_br_sel       = 1'b0;
         d_wb           = WB_NO_DATA;
         d_imm          = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid      <= 1'b0;
         alu_op         <= ALU_ADD;
         reg_write_en   <= 1'b0;
         br_type        <= BR_NONE;
         ram_write_en   <= 1'b0;
         ram_read_en    <= 1'b0;
         ram_type       <= RAM_NONE;
         ram_sign       <= 1'b0;
         mux_op1_select <= 1'b0;
         mux_op2_select <= 1'b0;
         mux_br_sel     <= 1'b0;
         mux_writeback  <= WB_NO_DATA;
         rs1            <= 5'd0;
         rs2            <= 5'd0;
         rd             <= 5'd0;
         imm            <= '0;
         out_pc         <= '0;
         illegal        <= 1'b0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (load_out) begin
         out_valid      <= 1'b1;
         alu_op         <= d_alu_op;
         reg_write_en   <= d_reg_write_en;
         br_type        <= d_br_type;
         ram_write_en   <= d_ram_write_en;
         ram_read_en    <= d_ram_read_en;
         ram_type       <= d_ram_type;
         ram_sign       <= d_ram_sign;
         mux_op1_select <= d_op1;
         mux_op2_select <= d_op2;
         mux_br_sel     <= d_br_sel;
         mux_writeback  <= d_wb;
         rs1            <= head[19:15];
         rs2            <= head[24:20];
         rd             <= head[11:7];
         imm            <= d_imm;
         out_pc         <= head_pc;
         illegal        <= !legal;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed corner cases plus random traffic, checked by a
// scoreboard against an ISA-level decode model. Honours DECODE_M_EN like the design.
module tb_decode_stage;
   localparam int XLEN   = 32;
   localparam int QDEPTH = 4;
`ifdef DECODE_M_EN
   localparam bit M_EN = 1'b1;
`else
   localparam bit M_EN = 1'b0;
`endif

   typedef struct packed {
      logic [4:0]      alu;
      logic            rw;
      logic [1:0]      br;
      logic            rwe;
      logic            rre;
      logic [3:0]      rtype;
      logic            rsign;
      logic            m1;
      logic            m2;
      logic            mbr;
      logic [1:0]      wb;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [4:0]      rd;
      logic [XLEN-1:0] imm;
      logic [XLEN-1:0] pc;
      logic            ill;
   } rec_t;

   logic            clk = 1'b0;
   logic            rst, in_valid, in_ready, flush, ex_valid, ex_is_load, out_valid, out_ready;
   logic [31:0]     in_instr;
   logic [XLEN-1:0] in_pc, imm, out_pc;
   logic [4:0]      ex_rd, alu_op, rs1, rs2, rd;
   logic            reg_write_en, ram_write_en, ram_read_en, ram_sign;
   logic            mux_op1_select, mux_op2_select, mux_br_sel, illegal;
   logic [1:0]      br_type, mux_writeback;
   logic [3:0]      ram_type;

   rec_t exp_q[$];
   int   total = 0;
   int   bad = 0;
   int   accepted = 0;
   bit   mon_en = 1'b0;

   decode_stage #(.XLEN(XLEN), .QDEPTH(QDEPTH)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
      .in_pc(in_pc), .flush(flush), .ex_valid(ex_valid), .ex_is_load(ex_is_load),
      .ex_rd(ex_rd), .out_valid(out_valid), .out_ready(out_ready), .alu_op(alu_op),
      .reg_write_en(reg_write_en), .br_type(br_type), .ram_write_en(ram_write_en),
      .ram_read_en(ram_read_en), .ram_type(ram_type), .ram_sign(ram_sign),
      .mux_op1_select(mux_op1_select), .mux_op2_select(mux_op2_select),
      .mux_br_sel(mux_br_sel), .mux_writeback(mux_writeback), .rs1(rs1), .rs2(rs2),
      .rd(rd), .imm(imm), .out_pc(out_pc), .illegal(illegal)
   );

   always #5 clk = ~clk;

   // ISA-level meaning of each encoding, expressed as lookup tables per instruction class.
   function automatic rec_t model(input logic [31:0] ins, input logic [XLEN-1:0] pc);
      rec_t       r, z;
      logic [4:0] arith [8];
      logic [4:0] cmp [8];
      logic [2:0] f3;
      logic [6:0] f7;
      bit         ok;
      arith = '{5'd0, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd8, 5'd9};
      cmp   = '{5'd11, 5'd12, 5'd0, 5'd0, 5'd13, 5'd14, 5'd15, 5'd16};
      f3 = ins[14:12];
      f7 = ins[31:25];
      r = '0;
      r.rsign = 1'b1;
      r.rs1 = ins[19:15];
      r.rs2 = ins[24:20];
      r.rd  = ins[11:7];
      r.pc  = pc;
      ok = 1'b1;
      case (ins[6:0])
         7'h33: begin
            r.rw = 1'b1; r.wb = 2'd1;
            if (f7 == 7'h00)                   r.alu = arith[f3];
            else if (f7 == 7'h20 && f3 == 3'd0) r.alu = 5'd1;
            else if (f7 == 7'h20 && f3 == 3'd5) r.alu = 5'd7;
            else if (f7 == 7'h01 && M_EN)      r.alu = 5'd24 + 5'(f3);
            else                               ok = 1'b0;
         end
         7'h13: begin
            r.rw = 1'b1; r.wb = 2'd1; r.m2 = 1'b1;
            r.imm = XLEN'($signed(ins[31:20]));
            r.alu = (f3 == 3'd5 && ins[30]) ? 5'd7 : arith[f3];
            if (f3 == 3'd1) ok = (f7 == 7'h00);
            if (f3 == 3'd5) ok = (f7 == 7'h00 || f7 == 7'h20);
         end
         7'h03: begin
            r.rw = 1'b1; r.rre = 1'b1; r.wb = 2'd2; r.m2 = 1'b1;
            r.imm = XLEN'($signed(ins[31:20]));
            ok = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
            r.rtype = 4'(1 << f3[1:0]);
            r.rsign = !f3[2];
         end
         7'h23: begin
            r.rwe = 1'b1; r.m2 = 1'b1;
            r.imm = XLEN'($signed({ins[31:25], ins[11:7]}));
            ok = (f3 < 3'd3);
            r.rtype = 4'(1 << f3[1:0]);
         end
         7'h63: begin
            r.br = 2'd1;
            r.imm = XLEN'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
            ok = (f3 != 3'd2 && f3 != 3'd3);
            r.alu = cmp[f3];
         end
         7'h6F: begin
            r.rw = 1'b1; r.wb = 2'd3; r.br = 2'd2; r.m1 = 1'b1; r.m2 = 1'b1;
            r.imm = XLEN'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
         end
         7'h67: begin
            r.rw = 1'b1; r.wb = 2'd3; r.br = 2'd3; r.m2 = 1'b1; r.mbr = 1'b1;
            r.imm = XLEN'($signed(ins[31:20]));
            ok = (f3 == 3'd0);
         end
         7'h37: begin
            r.rw = 1'b1; r.wb = 2'd1; r.alu = 5'd10; r.m2 = 1'b1;
            r.imm = {ins[31:12], 12'b0};
         end
         7'h17: begin
            r.rw = 1'b1; r.wb = 2'd1; r.m1 = 1'b1; r.m2 = 1'b1;
            r.imm = {ins[31:12], 12'b0};
         end
         default: ok = 1'b0;
      endcase
      if (!ok) begin
         z = '0;
         z.rsign = 1'b1;
         z.rs1 = r.rs1;
         z.rs2 = r.rs2;
         z.rd  = r.rd;
         z.pc  = pc;
         z.ill = 1'b1;
         r = z;
      end
      return r;
   endfunction

   function automatic rec_t actual();
      rec_t a;
      a = '{alu: alu_op, rw: reg_write_en, br: br_type, rwe: ram_write_en, rre: ram_read_en,
            rtype: ram_type, rsign: ram_sign, m1: mux_op1_select, m2: mux_op2_select,
            mbr: mux_br_sel, wb: mux_writeback, rs1: rs1, rs2: rs2, rd: rd, imm: imm,
            pc: out_pc, ill: illegal};
      return a;
   endfunction

   function automatic logic [31:0] gen_instr();
      logic [31:0] r;
      logic [6:0]  ops [10];
      ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h7F};
      r = $urandom;
      r[6:0]   = ops[$urandom_range(0, 9)];
      r[19:15] = 5'($urandom_range(0, 7));
      r[24:20] = 5'($urandom_range(0, 7));
      if ($urandom_range(0, 3) != 0) begin
         case ($urandom_range(0, 2))
            0:       r[31:25] = 7'h00;
            1:       r[31:25] = 7'h20;
            default: r[31:25] = 7'h01;
         endcase
      end
      return r;
   endfunction

   task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("[TB] FAIL %s: got %h, want %h", name, got, want);
      end
   endtask

   task automatic check_rec(input string name, input rec_t got, input rec_t want);
      total++;
      if (got !== want) begin
         bad++;
         $display("[TB] FAIL %s: got %h, want %h", name, got, want);
      end
   endtask

   // One clock; an accepted instruction's expected decode joins the scoreboard.
   task automatic apply_stimulus();
      @(negedge clk);
      if (!rst && in_valid && in_ready) begin
         exp_q.push_back(model(in_instr, in_pc));
         accepted++;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic issue_one(input logic [31:0] ins, input logic [XLEN-1:0] pc);
      in_valid = 1'b1; in_instr = ins; in_pc = pc; out_ready = 1'b1;
      apply_stimulus();
      in_valid = 1'b0;
      apply_stimulus();
      check_output("issue_valid", 32'(out_valid), 32'd1);
   endtask

   initial begin
      rec_t held;
      bit   stall_prev;
      stall_prev = 1'b0;
      held = '0;
      forever begin
         @(negedge clk);
         if (!mon_en) continue;
         if (rst) begin
            exp_q.delete();
            stall_prev = 1'b0;
         end else begin
            if (stall_prev) begin
               check_output("hold_valid", 32'(out_valid), 32'd1);
               check_rec("hold_fields", actual(), held);
            end
            if (flush) begin
               exp_q.delete();
            end else if (out_valid && out_ready) begin
               if (exp_q.size() == 0) begin
                  total++;
                  bad++;
                  $display("[TB] FAIL unexpected_output: got pc %h, want no output", out_pc);
               end else begin
                  check_rec("decode", actual(), exp_q.pop_front());
               end
            end
            stall_prev = out_valid && !out_ready && !flush;
            held = actual();
         end
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got timeout, want completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int base;
      logic [XLEN-1:0] pc_ctr;
      rst = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; flush = 1'b0;
      ex_valid = 1'b0; ex_is_load = 1'b0; ex_rd = '0; out_ready = 1'b0;
      #2 rst = 1'b1;
      #1;
      check_rec("reset_fields", actual(), '0);
      check_output("reset_valid", 32'(out_valid), 32'd0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
      mon_en = 1'b1;
      #1;
      check_output("in_ready_after_reset", 32'(in_ready), 32'd1);

      // ADDI x1,x0,5: latency of one cycle after acceptance.
      in_valid = 1'b1; in_instr = 32'h00500093; in_pc = 32'h100; out_ready = 1'b1;
      apply_stimulus();
      in_valid = 1'b0;
      check_output("addi_not_yet", 32'(out_valid), 32'd0);
      apply_stimulus();
      check_output("addi_valid", 32'(out_valid), 32'd1);
      check_output("addi_alu", 32'(alu_op), 32'd0);
      check_output("addi_imm", imm, 32'd5);
      check_output("addi_rd", 32'(rd), 32'd1);
      check_output("addi_rw", 32'(reg_write_en), 32'd1);
      apply_stimulus();

      // Load-use hazard on x3 against ADD x4,x3,x2.
      ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd3;
      in_valid = 1'b1; in_instr = 32'h00218233; in_pc = 32'h104;
      apply_stimulus();
      in_valid = 1'b0;
      apply_stimulus();
      check_output("hazard_bubble1", 32'(out_valid), 32'd0);
      apply_stimulus();
      check_output("hazard_bubble2", 32'(out_valid), 32'd0);
      ex_valid = 1'b0;
      apply_stimulus();
      check_output("hazard_release", 32'(out_valid), 32'd1);
      check_output("hazard_rd", 32'(rd), 32'd4);
      apply_stimulus();

      // Fill the queue with the consumer stalled, then drain in order.
      out_ready = 1'b0; in_valid = 1'b1;
      base = accepted;
      for (int i = 0; i < 20 && (accepted - base) < QDEPTH + 1; i++) begin
         in_instr = 32'h00000093 | (32'(i) << 20);
         in_pc = 32'h200 + 32'(i) * 4;
         apply_stimulus();
      end
      check_output("fill_count", 32'(accepted - base), 32'(QDEPTH + 1));
      check_output("full_in_ready", 32'(in_ready), 32'd0);
      in_pc = 32'hDEAD0;
      apply_stimulus();
      check_output("full_push_ignored", 32'(accepted - base), 32'(QDEPTH + 1));
      in_valid = 1'b0; out_ready = 1'b1;
      for (int i = 0; i < 20 && (exp_q.size() != 0 || out_valid); i++) apply_stimulus();
      check_output("fill_drained", 32'(exp_q.size()), 32'd0);

      // Flush with queued work and a flush-cycle instruction that must vanish.
      out_ready = 1'b0; in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_instr = 32'h00100113; in_pc = 32'h300 + 32'(i) * 4;
         apply_stimulus();
      end
      flush = 1'b1; in_instr = 32'h00700393; in_pc = 32'hF00;
      #1;
      check_output("flush_in_ready", 32'(in_ready), 32'd0);
      apply_stimulus();
      flush = 1'b0; in_valid = 1'b0;
      check_output("flush_valid", 32'(out_valid), 32'd0);
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         apply_stimulus();
         check_output("flush_stays_empty", 32'(out_valid), 32'd0);
      end

      // Field-level corner cases.
      issue_one(32'h00015083, 32'h400);
      check_output("lhu_type", 32'(ram_type), 32'd2);
      check_output("lhu_sign", 32'(ram_sign), 32'd0);
      issue_one(32'h00011083, 32'h404);
      check_output("lh_sign", 32'(ram_sign), 32'd1);
      issue_one(32'h0000007F, 32'h408);
      check_output("bad_opc_illegal", 32'(illegal), 32'd1);
      check_output("bad_opc_enables",
                   32'({reg_write_en, ram_write_en, ram_read_en, br_type}), 32'd0);
      issue_one(32'h027302B3, 32'h40C);
      check_output("mul_illegal", 32'(illegal), M_EN ? 32'd0 : 32'd1);
      check_output("mul_alu", 32'(alu_op), M_EN ? 32'd24 : 32'd0);
      apply_stimulus();

      // Reset in the middle of traffic loses everything in flight.
      out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h00500093;
      for (int i = 0; i < 2; i++) begin
         in_pc = 32'h500 + 32'(i) * 4;
         apply_stimulus();
      end
      rst = 1'b1;
      #1;
      check_output("midreset_valid", 32'(out_valid), 32'd0);
      in_valid = 1'b0;
      apply_stimulus();
      rst = 1'b0;
      #1;
      check_output("midreset_in_ready", 32'(in_ready), 32'd1);
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) apply_stimulus();
      check_output("midreset_empty", 32'(out_valid), 32'd0);

      // Random traffic with hazards, back-pressure and occasional flushes.
      pc_ctr = 32'h1000;
      for (int n = 0; n < 2000; n++) begin
         in_valid   = ($urandom_range(0, 3) != 0);
         in_instr   = gen_instr();
         in_pc      = pc_ctr;
         pc_ctr     = pc_ctr + 4;
         out_ready  = ($urandom_range(0, 3) != 0);
         ex_valid   = ($urandom_range(0, 2) == 0);
         ex_is_load = 1'($urandom_range(0, 1));
         ex_rd      = 5'($urandom_range(0, 7));
         flush      = ($urandom_range(0, 63) == 0);
         if (flush) out_ready = 1'b0;
         apply_stimulus();
      end
      flush = 1'b0; in_valid = 1'b0; ex_valid = 1'b0; out_ready = 1'b1;
      for (int i = 0; i < 40 && (exp_q.size() != 0 || out_valid); i++) apply_stimulus();
      check_output("random_drained", 32'(exp_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
